alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, operand width of the shared ALU; all result widths are 2*DW.
REQ-002 SHALL have port clk, input, 1, single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have ports reqN_valid input 1, reqN_ready output 1, reqN_op input 4, reqN_a input DW, reqN_b input DW, for N = 0 and 1; these are the requester channels.
REQ-005 SHALL have ports alu_op output 4, alu_a output DW, alu_b output DW; these drive the external combinational ALU.
REQ-006 SHALL have ports alu_result input 2*DW and alu_carry input 1; these are the ALU outputs.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (winning requester), rsp_result output 2*DW, rsp_carry output 1, rsp_err output 1.
REQ-008 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, ISSUE, RESP.
REQ-010 In IDLE, reqN_ready SHALL equal the grant for N; in ISSUE and RESP both ready outputs SHALL be 0.
REQ-011 Arbitration SHALL be round-robin:
- One valid request: that requester is granted.
- Both valid: the requester not granted last wins.
- After reset, requester 0 wins the first tie.
REQ-012 On a handshake at edge E, the FSM SHALL latch op, a, b and the id into internal registers, move to ISSUE, and update the last-grant pointer.
REQ-013 In ISSUE, alu_op, alu_a and alu_b SHALL present the latched values; in all other states they SHALL hold their last values.
REQ-014 At edge E+1, the FSM SHALL capture alu_result into rsp_result, set rsp_valid=1 and move to RESP; latency from handshake edge to rsp_valid is exactly 2 edges.
REQ-015 rsp_carry SHALL capture alu_carry for op 4'b0000 and 4'b0001 only, and SHALL be 0 for every other op.
REQ-016 In RESP, rsp_* SHALL stay stable until rsp_valid and rsp_ready are both high at an edge; at that edge rsp_valid clears and the FSM returns to IDLE.
REQ-017 A new request SHALL NOT be accepted in the same cycle as the response handshake; peak throughput is one operation per 3 cycles.
REQ-018 Requests arriving in ISSUE or RESP SHALL wait; a requester SHALL keep valid and operands stable until ready.
REQ-019 When requests are pending, the arbiter SHALL NOT starve either requester; the maximum wait is one foreign operation.
REQ-020 rsp_err SHALL be 0 unless REQ-026 applies.

Reset
REQ-021 While rst_n=0 at a clk edge, the FSM SHALL enter IDLE and last-grant SHALL point to requester 1.
REQ-022 While rst_n=0 at a clk edge, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, alu_op, alu_a, alu_b and busy SHALL all be cleared to 0.
REQ-023 Reset asserted during ISSUE or RESP SHALL abort the operation with no response produced.
REQ-024 In the first cycle after reset release, reqN_ready SHALL reflect arbitration.

Configuration
REQ-025 The macro ALU_DIVZERO_CHK_EN SHALL control divide-by-zero checking.
REQ-026 With ALU_DIVZERO_CHK_EN defined, a request with op 4'b0011 and b==0 SHALL skip ISSUE and go directly IDLE->RESP at the handshake edge.
- This response has rsp_err=1, rsp_result all ones, rsp_carry=0, and latency of 1 edge.
- alu_* outputs are not updated.
REQ-027 Without ALU_DIVZERO_CHK_EN, such a request SHALL follow the normal path; rsp_result is whatever alu_result gives, and rsp_err is always 0.

Verification
REQ-028 Bench SHALL drive req0 op=0000, a=8'hF0, b=8'h20, with rsp_ready=1 -> rsp_valid 2 edges after the handshake, rsp_result=16'h0110, rsp_carry=1, rsp_id=0.
REQ-029 Bench SHALL hold both requesters valid continuously for 4 operations after reset -> grants in order 0,1,0,1.
REQ-030 Bench SHALL drive req1 op=0010, a=8'h0F, b=8'h10, with rsp_ready=0 for 5 cycles -> rsp_result=16'h00F0 held stable, busy=1, both ready outputs 0, then a single response on release.
REQ-031 Bench SHALL drive op=0011, b=0 -> with macro: rsp_err=1 and rsp_result=16'hFFFF after 1 edge; without macro: rsp_err=0 after 2 edges.
REQ-032 Bench SHALL assert rst_n=0 during ISSUE of an op=1000 request -> next cycle IDLE, rsp_valid=0, outputs 0, no response emitted.
REQ-033 Bench SHALL drive op=1010 (XOR), a=8'hAA, b=8'hFF -> rsp_result=16'h0055, rsp_carry=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional macro ALU_DIVZERO_CHK_EN: divide-by-zero requests are answered at once with an error response.
module alu_arbiter #(
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [3:0]        req0_op,
   input  logic [DW-1:0]     req0_a,
   input  logic [DW-1:0]     req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [3:0]        req1_op,
   input  logic [DW-1:0]     req1_a,
   input  logic [DW-1:0]     req1_b,
   output logic [3:0]        alu_op,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   input  logic [2*DW-1:0]   alu_result,
   input  logic              alu_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [2*DW-1:0]   rsp_result,
   output logic              rsp_carry,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic                last_grant_r;
   logic                grant0_s;
   logic                grant1_s;
   logic                hs_s;
   logic                div_zero_s;
   logic [3:0]          sel_op_s;
   logic [DW-1:0]       sel_a_s;
   logic [DW-1:0]       sel_b_s;
   logic [3:0]          alu_op_r;
   logic [DW-1:0]       alu_a_r;
   logic [DW-1:0]       alu_b_r;
   logic                rsp_valid_r;
   logic                rsp_id_r;
   logic [2*DW-1:0]     rsp_result_r;
   logic                rsp_carry_r;
   logic                rsp_err_r;
   logic                busy_r;

   // Only add and subtract produce a meaningful carry/borrow.
   function automatic logic carry_valid(input logic [3:0] op);
      return (op[3:1] == 3'b000);
   endfunction

   // Round-robin grant: on a tie the requester not granted last wins.
   always_comb begin
      grant0_s = req0_valid & (~req1_valid | last_grant_r);
      grant1_s = req1_valid & (~req0_valid | ~last_grant_r);
      hs_s     = (state_r == IDLE) & (grant0_s | grant1_s);
      if (grant1_s) begin
         sel_op_s = req1_op;
         sel_a_s  = req1_a;
         sel_b_s  = req1_b;
      end else begin
         sel_op_s = req0_op;
         sel_a_s  = req0_a;
         sel_b_s  = req0_b;
      end
   end

`ifdef ALU_DIVZERO_CHK_EN
   assign div_zero_s = (sel_op_s == 4'b0011) && (sel_b_s == {DW{1'b0}});
`else
   assign div_zero_s = 1'b0;
`endif

   assign req0_ready = (state_r == IDLE) & grant0_s;
   assign req1_ready = (state_r == IDLE) & grant1_s;

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (hs_s) begin
               state_s = div_zero_s ? RESP : ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: state_s = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State, grant pointer, ALU operand and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         alu_op_r     <= 4'b0000;
         alu_a_r      <= {DW{1'b0}};
         alu_b_r      <= {DW{1'b0}};
         rsp_valid_r  <= 1'b0;
         rsp_id_r     <= 1'b0;
         rsp_result_r <= {2*DW{1'b0}};
         rsp_carry_r  <= 1'b0;
         rsp_err_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         if (hs_s) begin
            last_grant_r <= grant1_s;
            rsp_id_r     <= grant1_s;
            if (div_zero_s) begin
               // Short-circuit: the ALU operands are left untouched.
               rsp_valid_r  <= 1'b1;
               rsp_result_r <= {2*DW{1'b1}};
               rsp_carry_r  <= 1'b0;
               rsp_err_r    <= 1'b1;
            end else begin
               alu_op_r <= sel_op_s;
               alu_a_r  <= sel_a_s;
               alu_b_r  <= sel_b_s;
            end
         end else if (state_r == ISSUE) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= alu_result;
            rsp_carry_r  <= alu_carry & carry_valid(alu_op_r);
            rsp_err_r    <= 1'b0;
         end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
         end
      end
   end

   assign alu_op     = alu_op_r;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_result = rsp_result_r;
   assign rsp_carry  = rsp_carry_r;
   assign rsp_err    = rsp_err_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Build with ALU_DIVZERO_CHK_EN defined to exercise the divide-by-zero short-circuit.
module tb_alu_arbiter;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_op, req1_op, alu_op;
   logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
   logic [15:0] alu_result, rsp_result;
   logic alu_carry, rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   bit   m_accept_ok, m_due, m_showing, m_hs;
   int   m_last;
   logic m_id, m_carry, m_err;
   logic [15:0] m_result;
   logic [3:0]  m_alu_op;
   logic [7:0]  m_alu_a, m_alu_b;
   bit keep_valid = 1'b0;
   bit rand_mode  = 1'b0;

   alu_arbiter #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
   );

   // External ALU: carry is forced high for ops whose carry must be discarded.
   function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] r;
      logic c;
      c = 1'b1;
      case (op)
         4'b0000: begin r = {8'h00, a} + {8'h00, b}; c = r[8]; end
         4'b0001: begin r = {8'h00, a - b}; c = (a < b); end
         4'b0010: r = {8'h00, a} * {8'h00, b};
         4'b0011: r = (b == 8'h00) ? 16'hDEAD : {8'h00, a / b};
         4'b1010: r = {8'h00, a ^ b};
         default: r = {a, b};
      endcase
      return {c, r};
   endfunction

   always_comb {alu_carry, alu_result} = alu_f(alu_op, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_req(input int n, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      if (n == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic rand_req(input int n);
      logic [3:0] op;
      logic [7:0] b;
      case ($urandom_range(6, 0))
         0: op = 4'b0000;
         1: op = 4'b0001;
         2: op = 4'b0010;
         3: op = 4'b0011;
         4: op = 4'b1000;
         5: op = 4'b1010;
         default: op = 4'($urandom);
      endcase
      b = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom);
      set_req(n, op, 8'($urandom), b);
   endtask

   // One clock: check ready against the model, advance model over the edge, check registered outputs.
   task automatic step();
      bit v0, v1, rr, rst, dz;
      logic [3:0] op;
      logic [7:0] a, b;
      logic [16:0] f;
      int w;
      #1;
      v0 = req0_valid; v1 = req1_valid; rr = rsp_ready; rst = rst_n;
      w = (v0 && v1) ? (1 - m_last) : (v1 ? 1 : 0);
      op = (w == 1) ? req1_op : req0_op;
      a  = (w == 1) ? req1_a  : req0_a;
      b  = (w == 1) ? req1_b  : req0_b;
      if (rst) begin
         check("req0_ready", req0_ready, m_accept_ok && v0 && (w == 0));
         check("req1_ready", req1_ready, m_accept_ok && v1 && (w == 1));
      end
      @(posedge clk);
      #1;
      m_hs = 1'b0;
      if (!rst) begin
         m_accept_ok = 1'b1; m_due = 1'b0; m_showing = 1'b0; m_last = 1;
         m_id = 1'b0; m_result = 16'h0000; m_carry = 1'b0; m_err = 1'b0;
         m_alu_op = 4'b0000; m_alu_a = 8'h00; m_alu_b = 8'h00;
      end else if (m_accept_ok && (v0 || v1)) begin
         m_hs = 1'b1; m_last = w; m_accept_ok = 1'b0; m_id = (w == 1);
         f = alu_f(op, a, b);
`ifdef ALU_DIVZERO_CHK_EN
         dz = (op == 4'b0011) && (b == 8'h00);
`else
         dz = 1'b0;
`endif
         if (dz) begin
            m_showing = 1'b1; m_result = 16'hFFFF; m_carry = 1'b0; m_err = 1'b1;
         end else begin
            m_due = 1'b1; m_alu_op = op; m_alu_a = a; m_alu_b = b;
            m_result = f[15:0];
            m_carry = ((op == 4'b0000) || (op == 4'b0001)) ? f[16] : 1'b0;
            m_err = 1'b0;
         end
      end else if (m_due) begin
         m_due = 1'b0; m_showing = 1'b1;
      end else if (m_showing && rr) begin
         m_showing = 1'b0; m_accept_ok = 1'b1;
      end
      check("rsp_valid", rsp_valid, m_showing);
      check("busy", busy, !m_accept_ok);
      check("alu_op", alu_op, m_alu_op);
      check("alu_a", alu_a, m_alu_a);
      check("alu_b", alu_b, m_alu_b);
      if (m_showing || !rst) begin
         check("rsp_id", rsp_id, m_id);
         check("rsp_result", rsp_result, m_result);
         check("rsp_carry", rsp_carry, m_carry);
         check("rsp_err", rsp_err, m_err);
      end
      if (m_hs && !keep_valid) begin
         if (w == 1) req1_valid = 1'b0;
         else req0_valid = 1'b0;
      end
      if (rand_mode) begin
         if (!req0_valid && ($urandom_range(1, 0) == 1)) rand_req(0);
         if (!req1_valid && ($urandom_range(1, 0) == 1)) rand_req(1);
         rsp_ready = ($urandom_range(3, 0) != 0);
      end
   endtask

   task automatic run_until_hs();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         step();
         ok = m_hs;
      end
      check("hs_seen", ok, 1'b1);
   endtask

   // Edges from the handshake edge (inclusive) until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 1;
      for (int i = 0; i < 10 && !rsp_valid; i++) begin
         step();
         lat++;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && !(m_accept_ok && !m_showing); i++) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int ids[$];
      bit pv;
      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_op = 4'b0000; req0_a = 8'h00; req0_b = 8'h00;
      req1_valid = 1'b0; req1_op = 4'b0000; req1_a = 8'h00; req1_b = 8'h00;
      m_accept_ok = 1'b1; m_last = 1;
      @(posedge clk);
      step();
      step();
      rst_n = 1'b1;

      // Both requesters held valid: grants alternate starting with 0.
      keep_valid = 1'b1;
      set_req(0, 4'b0000, 8'h11, 8'h22);
      set_req(1, 4'b0010, 8'h03, 8'h04);
      for (int i = 0; i < 40 && ids.size() < 4; i++) begin
         pv = rsp_valid;
         step();
         if (rsp_valid && !pv) ids.push_back(int'(rsp_id));
      end
      check("rr_count", ids.size(), 4);
      foreach (ids[i]) check("rr_order", ids[i], i % 2);
      keep_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      drain();

      // Add with carry out.
      set_req(0, 4'b0000, 8'hF0, 8'h20);
      run_until_hs();
      wait_rsp(lat);
      check("add_lat", lat, 2);
      check("add_result", rsp_result, 16'h0110);
      check("add_carry", rsp_carry, 1'b1);
      check("add_id", rsp_id, 1'b0);
      drain();

      // XOR discards the ALU carry.
      set_req(0, 4'b1010, 8'hAA, 8'hFF);
      run_until_hs();
      wait_rsp(lat);
      check("xor_lat", lat, 2);
      check("xor_result", rsp_result, 16'h0055);
      check("xor_carry", rsp_carry, 1'b0);
      drain();

      // Backpressure: response held while another request waits.
      rsp_ready = 1'b0;
      set_req(1, 4'b0010, 8'h0F, 8'h10);
      run_until_hs();
      wait_rsp(lat);
      check("bp_lat", lat, 2);
      set_req(0, 4'b0000, 8'h01, 8'h02);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_result", rsp_result, 16'h00F0);
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_busy", busy, 1'b1);
         check("bp_ready0", req0_ready, 1'b0);
         check("bp_ready1", req1_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      step();
      check("bp_release", rsp_valid, 1'b0);
      run_until_hs();
      wait_rsp(lat);
      check("bp_next_id", rsp_id, 1'b0);
      check("bp_next_result", rsp_result, 16'h0003);
      drain();

      // Divide by zero.
      set_req(0, 4'b0011, 8'h55, 8'h00);
      run_until_hs();
      wait_rsp(lat);
`ifdef ALU_DIVZERO_CHK_EN
      check("dz_lat", lat, 1);
      check("dz_err", rsp_err, 1'b1);
      check("dz_result", rsp_result, 16'hFFFF);
      check("dz_carry", rsp_carry, 1'b0);
`else
      check("dz_lat", lat, 2);
      check("dz_err", rsp_err, 1'b0);
      check("dz_result", rsp_result, 16'hDEAD);
`endif
      drain();

      // Reset during ISSUE aborts the operation.
      set_req(0, 4'b1000, 8'h12, 8'h34);
      run_until_hs();
      check("abort_in_issue", busy, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_valid", rsp_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_alu_op", alu_op, 4'b0000);
      check("abort_result", rsp_result, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_rsp", rsp_valid, 1'b0);
      end

      // Random traffic against the model.
      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) step();
      rand_mode = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
